fb_rect_fill: RTL and testbench

//  Rectangle-fill/clear engine and write-port arbiter for the 100x75-cell VGA framebuffer
//  (16384x8 dual-port BRAM, address = 128*row + col).

---
 rtl/fb_rect_fill.sv | 148 ++++++++++++++
 tb/tb_fb_rect_fill.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle fill/clear engine and write-port arbiter for the 100x75-cell
// VGA framebuffer. CPU writes always take the port; the engine fills a
// clipped rectangle one cell per free cycle, optionally waiting for vblank.
module fb_rect_fill #(
    parameter int COLS        = 100,
    parameter int ROWS        = 75,
    parameter int ADDR_W      = 14,
    parameter int ROW_SHIFT   = 7,
    parameter bit SYNC_VBLANK = 1'b1
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [7:0]        cpu_wr_data,
    input  logic              start,
    input  logic [6:0]        x0,
    input  logic [6:0]        x1,
    input  logic [6:0]        y0,
    input  logic [6:0]        y1,
    input  logic [7:0]        color,
    input  logic              vblank,
    input  logic              abort,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [7:0]        fb_wr_data,
    output logic              busy,
    output logic              done
);
    localparam int CW = 7;
    localparam logic [CW-1:0] X_MAX = CW'(COLS - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_FILL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]     x0_q, x0_d, x1c_q, x1c_d, y1c_q, y1c_d;
    logic [7:0]        color_q, color_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic [CW-1:0]     x1_clip, y1_clip;
    logic              rect_empty, eng_issue, last_cell;
    logic [ADDR_W-1:0] cell_addr;

    assign x1_clip    = (x1 > X_MAX) ? X_MAX : x1;
    assign y1_clip    = (y1 > Y_MAX) ? Y_MAX : y1;
    assign rect_empty = (x0 > x1_clip) || (y0 > y1_clip);
    // Engine only gets the port in a free cycle; an abort cancels the issue
    // in its own cycle so nothing new is written after it.
    assign eng_issue  = (state_q == S_FILL) && !cpu_wr_en && !abort;
    assign last_cell  = (cx_q == x1c_q) && (cy_q == y1c_q);
    assign cell_addr  = (ADDR_W'(cy_q) << ROW_SHIFT) | ADDR_W'(cx_q);

    assign fb_wr_en   = wr_en_q;
    assign fb_wr_addr = wr_addr_q;
    assign fb_wr_data = wr_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    // Next-state: port arbitration, fill FSM and cursor stepping.
    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        x1c_d     = x1c_q;
        y1c_d     = y1c_q;
        color_d   = color_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (cpu_wr_en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cpu_wr_addr;
            wr_data_d = cpu_wr_data;
        end else if (eng_issue) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr;
            wr_data_d = color_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1c_d   = x1_clip;
                    y1c_d   = y1_clip;
                    color_d = color;
                    cx_d    = x0;
                    cy_d    = y0;
                    if (rect_empty)       state_d = S_DONE;
                    else if (SYNC_VBLANK) state_d = S_WAIT_VB;
                    else                  state_d = S_FILL;
                end
            end
            S_WAIT_VB: begin
                if (abort)       state_d = S_IDLE;
                else if (vblank) state_d = S_FILL;
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (eng_issue) begin
                    if (last_cell) state_d = S_DONE;
                    if (cx_q == x1c_q) begin
                        cx_d = x0_q;
                        cy_d = cy_q + 7'd1;
                    end else begin
                        cx_d = cx_q + 7'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, cursor and registered write-port outputs.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q   <= S_IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            x0_q      <= '0;
            x1c_q     <= '0;
            y1c_q     <= '0;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            x1c_q     <= x1c_d;
            y1c_q     <= y1c_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: a scoreboard of expected fill and
// CPU writes, popped as the framebuffer port produces them.
module tb_fb_rect_fill;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_en;
    logic [13:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        start;
    logic [6:0]  x0, x1, y0, y1;
    logic [7:0]  color;
    logic        vblank;
    logic        abort;
    logic        fb_wr_en;
    logic [13:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;
    logic        busy;
    logic        done;

    fb_rect_fill dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .start       (start),
        .x0          (x0),
        .x1          (x1),
        .y0          (y0),
        .y1          (y1),
        .color       (color),
        .vblank      (vblank),
        .abort       (abort),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef logic [21:0] wr_t;   // {addr, data}
    wr_t fill_q[$];
    wr_t cpu_q[$];

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;
    int fill_seen = 0;
    int cpu_seen  = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    logic [13:0] last_fill_addr = '0;
    bit   done_with_write = 1'b0;
    logic cpu_prev;

    // Remembers whether the cycle just accepted carried a CPU write.
    always @(posedge clk or posedge rst) begin
        if (rst) cpu_prev <= 1'b0;
        else     cpu_prev <= cpu_wr_en;
    end

    // Scoreboard: every port write must match the head of the right queue.
    always @(negedge clk) begin
        wr_t got, exp;
        got = {fb_wr_addr, fb_wr_data};
        if (fb_wr_en) begin
            asserts++;
            if (cpu_prev) begin
                cpu_seen++;
                if (cpu_q.size() == 0) begin
                    fails++;
                    $display("FAIL cpu_write: got unexpected %h", got);
                end else begin
                    exp = cpu_q.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL cpu_write: got %h expected %h", got, exp);
                    end
                end
            end else begin
                fill_seen++;
                last_fill_addr = fb_wr_addr;
                if (fill_q.size() == 0) begin
                    fails++;
                    $display("FAIL fill_write: got unexpected %h", got);
                end else begin
                    exp = fill_q.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL fill_write: got %h expected %h", got, exp);
                    end
                end
            end
        end else if (cpu_prev) begin
            asserts++;
            fails++;
            $display("FAIL cpu_write: missing, fb_wr_en=%b expected 1", fb_wr_en);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_with_write = fb_wr_en && !cpu_prev;
        end
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                             input logic [7:0] c);
        int xe;
        int ye;
        xe = (ax1 > 99) ? 99 : ax1;
        ye = (ay1 > 74) ? 74 : ay1;
        for (int y = ay0; y <= ye; y++)
            for (int x = ax0; x <= xe; x++)
                fill_q.push_back({14'(y * 128 + x), c});
    endtask

    task automatic do_start(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [7:0] c, input bit push);
        if (push) push_rect(ax0, ay0, ax1, ay1, c);
        x0 = 7'(ax0); y0 = 7'(ay0); x1 = 7'(ax1); y1 = 7'(ay1); color = c;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_wr_en = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
        start = 0; x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        vblank = 0; abort = 0;
        tick(); tick();
        asserts++;
        if ({fb_wr_en, fb_wr_addr, fb_wr_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b expected all 0",
                     fb_wr_en, fb_wr_addr, fb_wr_data, busy, done);
        end
        rst = 1'b0;
        tick(); tick();
        asserts++;
        if (busy !== 1'b0 || fb_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b en=%b expected 0 0", busy, fb_wr_en);
        end
    endtask

    task automatic test_full_fill();
        int fs0, dc0;
        bit ok;
        vblank = 1'b1;
        fs0 = fill_seen; dc0 = done_cnt;
        do_start(0, 0, 99, 74, 8'h00, 1);
        wait_idle(8000, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL full_timeout: busy=%b expected 0", busy); end
        asserts++;
        if (fill_seen - fs0 != 7500) begin
            fails++; $display("FAIL full_count: got %0d expected 7500", fill_seen - fs0);
        end
        asserts++;
        if (last_fill_addr !== 14'h2563) begin
            fails++; $display("FAIL full_last_addr: got %h expected 2563", last_fill_addr);
        end
        asserts++;
        if (done_cnt - dc0 != 1 || !done_with_write) begin
            fails++;
            $display("FAIL full_done: pulses=%0d with_write=%b expected 1 1", done_cnt - dc0, done_with_write);
        end
        asserts++;
        if (fill_q.size() != 0) begin
            fails++; $display("FAIL full_remaining: got %0d expected 0", fill_q.size());
        end
    endtask

    task automatic test_vblank_wait();
        int fs0, bad;
        bit ok;
        vblank = 1'b0;
        fs0 = fill_seen; bad = 0;
        do_start(0, 0, 1, 0, 8'h55, 1);
        for (int i = 0; i < 50; i++) begin
            if (busy !== 1'b1 || fb_wr_en !== 1'b0) bad++;
            tick();
        end
        asserts++;
        if (bad != 0 || fill_seen != fs0) begin
            fails++; $display("FAIL vblank_hold: bad_cycles=%0d writes=%0d expected 0 0", bad, fill_seen - fs0);
        end
        vblank = 1'b1;
        wait_idle(50, ok);
        asserts++;
        if (!ok || fill_seen - fs0 != 2 || fill_q.size() != 0) begin
            fails++; $display("FAIL vblank_fill: ok=%b writes=%0d expected 1 2", ok, fill_seen - fs0);
        end
    endtask

    task automatic test_cpu_arb();
        int fs0, cs0, solo, mixed;
        bit ok;
        do_start(10, 5, 12, 6, 8'hE0, 1);
        wait_idle(50, ok);
        solo = done_cyc - start_cyc;
        asserts++;
        if (!ok || solo != 8) begin
            fails++; $display("FAIL solo_latency: got %0d expected 8", solo);
        end
        fs0 = fill_seen; cs0 = cpu_seen;
        do_start(10, 5, 12, 6, 8'hE0, 1);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            cpu_wr_en = 1'b1; cpu_wr_addr = 14'h1234; cpu_wr_data = 8'h1C;
            cpu_q.push_back({14'h1234, 8'h1C});
            tick();
        end
        cpu_wr_en = 1'b0;
        wait_idle(50, ok);
        mixed = done_cyc - start_cyc;
        asserts++;
        if (!ok || mixed != solo + 3) begin
            fails++; $display("FAIL stall_latency: got %0d expected %0d", mixed, solo + 3);
        end
        asserts++;
        if (fill_seen - fs0 != 6 || cpu_seen - cs0 != 3) begin
            fails++; $display("FAIL arb_counts: fill=%0d cpu=%0d expected 6 3", fill_seen - fs0, cpu_seen - cs0);
        end
        asserts++;
        if (fill_q.size() != 0 || cpu_q.size() != 0) begin
            fails++; $display("FAIL arb_remaining: fill=%0d cpu=%0d expected 0 0", fill_q.size(), cpu_q.size());
        end
    endtask

    task automatic test_clip();
        int fs0, dc0;
        bit ok;
        fs0 = fill_seen;
        do_start(5, 70, 127, 100, 8'hA5, 1);
        wait_idle(1000, ok);
        asserts++;
        if (!ok || fill_seen - fs0 != 475 || fill_q.size() != 0) begin
            fails++; $display("FAIL clip_count: got %0d expected 475", fill_seen - fs0);
        end
        asserts++;
        if (last_fill_addr !== 14'h2563) begin
            fails++; $display("FAIL clip_last_addr: got %h expected 2563", last_fill_addr);
        end
        fs0 = fill_seen; dc0 = done_cnt;
        do_start(100, 0, 127, 0, 8'h11, 1);
        wait_idle(20, ok);
        tick();
        asserts++;
        if (!ok || fill_seen != fs0 || done_cnt - dc0 != 1) begin
            fails++; $display("FAIL empty_rect: writes=%0d dones=%0d expected 0 1", fill_seen - fs0, done_cnt - dc0);
        end
        asserts++;
        if (done_cyc - start_cyc != 1) begin
            fails++; $display("FAIL empty_done_latency: got %0d expected 1", done_cyc - start_cyc);
        end
    endtask

    task automatic test_abort();
        int fs0, fsa, dc0;
        bit reached;
        fs0 = fill_seen; dc0 = done_cnt;
        do_start(0, 0, 99, 74, 8'h3C, 1);
        for (int i = 0; i < 8; i++) tick();
        do_start(0, 0, 0, 0, 8'hFF, 0);   // must be ignored while busy
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fill_seen - fs0 >= 20) begin reached = 1'b1; break; end
            tick();
        end
        asserts++;
        if (!reached) begin fails++; $display("FAIL abort_setup: writes=%0d expected 20", fill_seen - fs0); end
        abort = 1'b1;
        fsa = fill_seen;
        tick();
        abort = 1'b0;
        asserts++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int i = 0; i < 10; i++) tick();
        asserts++;
        if (fill_seen - fsa > 1) begin
            fails++; $display("FAIL abort_writes: got %0d expected <=1", fill_seen - fsa);
        end
        asserts++;
        if (done_cnt != dc0) begin
            fails++; $display("FAIL abort_done: pulses=%0d expected 0", done_cnt - dc0);
        end
        fill_q.delete();
    endtask

    task automatic test_reset_mid();
        int fs0;
        bit ok;
        do_start(0, 0, 99, 74, 8'h77, 1);
        for (int i = 0; i < 30; i++) tick();
        #2 rst = 1'b1;
        #1;
        asserts++;
        if ({fb_wr_en, fb_wr_addr, fb_wr_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL async_reset: got en=%b addr=%h data=%h busy=%b done=%b expected all 0",
                     fb_wr_en, fb_wr_addr, fb_wr_data, busy, done);
        end
        tick(); tick();
        fill_q.delete();
        rst = 1'b0;
        tick();
        fs0 = fill_seen;
        do_start(2, 3, 4, 3, 8'h81, 1);
        wait_idle(50, ok);
        asserts++;
        if (!ok || fill_seen - fs0 != 3 || fill_q.size() != 0 || !done_with_write) begin
            fails++; $display("FAIL post_reset_fill: writes=%0d done_w=%b expected 3 1", fill_seen - fs0, done_with_write);
        end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_vblank_wait();
        test_cpu_arb();
        test_clip();
        test_abort();
        test_reset_mid();
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
